// File: rtl/div_reg_bank_if.sv
// Operand/iterate register bank bus: load strobes and multiplier result in,
// held operands and their valid flags out.
interface div_reg_bank_if #(
  parameter int WIDTH_IN = 28,
  parameter int WIDTH_A  = 28,
  parameter int WIDTH_BC = 24
);
  logic                load_a;
  logic                load_b;
  logic                load_c;
  logic [WIDTH_IN-1:0] d_in;
  logic [WIDTH_A-1:0]  q_a;
  logic [WIDTH_BC-1:0] q_b;
  logic [WIDTH_BC-1:0] q_c;
  logic                vld_a;
  logic                vld_b;
  logic                vld_c;

  modport master (
    output load_a, load_b, load_c, d_in,
    input  q_a, q_b, q_c, vld_a, vld_b, vld_c
  );

  modport slave (
    input  load_a, load_b, load_c, d_in,
    output q_a, q_b, q_c, vld_a, vld_b, vld_c
  );
endinterface

// File: rtl/div_reg_bank.sv
// Goldschmidt divider operand registers A/B/C, loaded from the rounded
// multiplier result under per-register synchronous enables on a single clock.
module div_reg_bank #(
  parameter int   WIDTH_IN = 28,
  parameter int   WIDTH_A  = 28,
  parameter int   WIDTH_BC = 24,
  parameter logic RST_VAL  = 1'b0
) (
  input logic           clk,
  input logic           reset,
  div_reg_bank_if.slave bus
);
  logic [WIDTH_A-1:0]  q_a_r;
  logic [WIDTH_BC-1:0] q_b_r;
  logic [WIDTH_BC-1:0] q_c_r;
  logic                vld_a_r;
  logic                vld_b_r;
  logic                vld_c_r;

  // Register A: full-width operand; reset wins over a concurrent load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_a_r   <= {WIDTH_A{RST_VAL}};
      vld_a_r <= 1'b0;
    end else if (bus.load_a) begin
      q_a_r   <= bus.d_in[WIDTH_A-1:0];
      vld_a_r <= 1'b1;
    end else begin
      q_a_r   <= q_a_r;
      vld_a_r <= vld_a_r;
    end
  end

  // Register B: narrower operand, upper result bits are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_b_r   <= {WIDTH_BC{RST_VAL}};
      vld_b_r <= 1'b0;
    end else if (bus.load_b) begin
      q_b_r   <= bus.d_in[WIDTH_BC-1:0];
      vld_b_r <= 1'b1;
    end else begin
      q_b_r   <= q_b_r;
      vld_b_r <= vld_b_r;
    end
  end

  // Register C: same truncation as B, independent enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_c_r   <= {WIDTH_BC{RST_VAL}};
      vld_c_r <= 1'b0;
    end else if (bus.load_c) begin
      q_c_r   <= bus.d_in[WIDTH_BC-1:0];
      vld_c_r <= 1'b1;
    end else begin
      q_c_r   <= q_c_r;
      vld_c_r <= vld_c_r;
    end
  end

  assign bus.q_a   = q_a_r;
  assign bus.q_b   = q_b_r;
  assign bus.q_c   = q_c_r;
  assign bus.vld_a = vld_a_r;
  assign bus.vld_b = vld_b_r;
  assign bus.vld_c = vld_c_r;
endmodule

// File: tb/tb_div_reg_bank.sv
// Directed self-checking bench for div_reg_bank: reset override, single and
// combined loads, truncation, hold under random d_in, and mid-sequence reset.
module tb_div_reg_bank;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  div_reg_bank_if #(.WIDTH_IN(28), .WIDTH_A(28), .WIDTH_BC(24)) bus ();

  div_reg_bank #(
    .WIDTH_IN(28),
    .WIDTH_A (28),
    .WIDTH_BC(24),
    .RST_VAL (1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic la, input logic lb, input logic lc, input logic [27:0] d);
    bus.load_a = la;
    bus.load_b = lb;
    bus.load_c = lc;
    bus.d_in   = d;
  endtask

  task automatic check_all(input string tag, input logic [27:0] ea, input logic [23:0] eb,
                           input logic [23:0] ec, input logic [2:0] ev);
    check({tag, ".q_a"},   {4'h0, bus.q_a},   {4'h0, ea});
    check({tag, ".q_b"},   {8'h00, bus.q_b},  {8'h00, eb});
    check({tag, ".q_c"},   {8'h00, bus.q_c},  {8'h00, ec});
    check({tag, ".vld_a"}, {31'd0, bus.vld_a}, {31'd0, ev[2]});
    check({tag, ".vld_b"}, {31'd0, bus.vld_b}, {31'd0, ev[1]});
    check({tag, ".vld_c"}, {31'd0, bus.vld_c}, {31'd0, ev[0]});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset held two cycles with every load asserted: reset must win.
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 28'hFFFFFFF);
    tick();
    tick();
    check_all("reset", 28'h0000000, 24'h000000, 24'h000000, 3'b000);

    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 28'h0600000);
    tick();
    check_all("load_a", 28'h0600000, 24'h000000, 24'h000000, 3'b100);

    drive(1'b0, 1'b0, 1'b0, 28'h5555555);
    tick();
    check_all("hold1", 28'h0600000, 24'h000000, 24'h000000, 3'b100);

    drive(1'b0, 1'b1, 1'b0, 28'hABCDEF1);
    tick();
    check_all("load_b", 28'h0600000, 24'hBCDEF1, 24'h000000, 3'b110);

    drive(1'b0, 1'b0, 1'b1, 28'h0FEDCBA);
    tick();
    check_all("load_c", 28'h0600000, 24'hBCDEF1, 24'hFEDCBA, 3'b111);

    drive(1'b1, 1'b1, 1'b1, 28'h1234567);
    tick();
    check_all("load_abc", 28'h1234567, 24'h234567, 24'h234567, 3'b111);

    // Idle with scrambled d_in: nothing may move.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 28'($urandom()));
      tick();
      check_all($sformatf("idle%0d", i), 28'h1234567, 24'h234567, 24'h234567, 3'b111);
    end

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 28'h0111111);
    tick();
    check_all("mid_reset", 28'h0000000, 24'h000000, 24'h000000, 3'b000);

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 28'h0222222);
    tick();
    check_all("post_reset_hold", 28'h0000000, 24'h000000, 24'h000000, 3'b000);

    drive(1'b0, 1'b1, 1'b0, 28'h8000001);
    tick();
    check_all("reload_b", 28'h0000000, 24'h000001, 24'h000000, 3'b010);

    drive(1'b1, 1'b0, 1'b1, 28'hFFFFFFF);
    tick();
    check_all("load_ac_ones", 28'hFFFFFFF, 24'h000001, 24'hFFFFFF, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
